// File: rtl/mlp_node_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed 2-2-1 threshold-neuron sequencer.
package mlp_pkg;

  localparam int unsigned WEIGHT_W    = 4;
  localparam int unsigned ACC_W       = 6;
  localparam int unsigned NUM_WEIGHTS = 9;

  localparam logic [3:0] IDX_A_WA = 4'd0;
  localparam logic [3:0] IDX_A_WB = 4'd1;
  localparam logic [3:0] IDX_A_B  = 4'd2;
  localparam logic [3:0] IDX_B_WA = 4'd3;
  localparam logic [3:0] IDX_B_WB = 4'd4;
  localparam logic [3:0] IDX_B_B  = 4'd5;
  localparam logic [3:0] IDX_C_WA = 4'd6;
  localparam logic [3:0] IDX_C_WB = 4'd7;
  localparam logic [3:0] IDX_C_B  = 4'd8;

  typedef enum logic [2:0] {
    StIdle,
    StEvalA,
    StEvalB,
    StEvalC,
    StDone
  } state_e;

endpackage

// File: rtl/mlp_node_scheduler_if.sv
// Config, sample-in and result-out handshakes of the scheduler, plus its busy flag.
interface mlp_node_scheduler_if;
  import mlp_pkg::*;

  logic                       cfg_we;
  logic [3:0]                 cfg_addr;
  logic signed [WEIGHT_W-1:0] cfg_wdata;
  logic                       cfg_ready;
  logic                       cfg_err;
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 in_x;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_y;
  logic                       busy;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_x, out_ready,
    input  cfg_ready, cfg_err, in_ready, out_valid, out_y, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_x, out_ready,
    output cfg_ready, cfg_err, in_ready, out_valid, out_y, busy
  );

endinterface

// File: rtl/mlp_node_scheduler_neuron_eval.sv
// Combinational threshold neuron: acc = x1*wA + x2*wB - b, fire when acc > THRESHOLD.
module neuron_eval
  import mlp_pkg::*;
#(
  parameter logic signed [ACC_W-1:0] THRESHOLD = '0
) (
  input  logic                       x1_i,
  input  logic                       x2_i,
  input  logic signed [WEIGHT_W-1:0] wa_i,
  input  logic signed [WEIGHT_W-1:0] wb_i,
  input  logic signed [WEIGHT_W-1:0] b_i,
  output logic                       fire_o,
  output logic signed [ACC_W-1:0]    acc_o
);

  logic signed [ACC_W-1:0] term_a;
  logic signed [ACC_W-1:0] term_b;
  logic signed [ACC_W-1:0] bias;

  // Worst case -8-8-7 / 7+7+8 stays inside ACC_W, so no saturation is needed.
  assign term_a = x1_i ? {{(ACC_W-WEIGHT_W){wa_i[WEIGHT_W-1]}}, wa_i} : '0;
  assign term_b = x2_i ? {{(ACC_W-WEIGHT_W){wb_i[WEIGHT_W-1]}}, wb_i} : '0;
  assign bias   = {{(ACC_W-WEIGHT_W){b_i[WEIGHT_W-1]}}, b_i};

  assign acc_o  = term_a + term_b - bias;
  assign fire_o = acc_o > THRESHOLD;

endmodule

// File: rtl/mlp_node_scheduler.sv
// Steps one shared neuron evaluator through hidden nodes A, B and output node C,
// with a runtime-writable weight file and valid/ready sample and result ports.
module mlp_node_scheduler
  import mlp_pkg::*;
#(
  parameter logic signed [ACC_W-1:0] THRESHOLD = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  mlp_node_scheduler_if.slave  sched_io
);

  state_e                     state_q, state_d;
  logic [1:0]                 x_q, x_d;
  logic                       h_a_q, h_a_d;
  logic                       h_b_q, h_b_d;
  logic                       out_y_q, out_y_d;
  logic                       cfg_err_q, cfg_err_d;
  logic signed [WEIGHT_W-1:0] weights_q [NUM_WEIGHTS];
  logic signed [WEIGHT_W-1:0] weights_d [NUM_WEIGHTS];

  logic                       in_ready;
  logic                       cfg_ok;
  logic                       op_x1, op_x2;
  logic signed [WEIGHT_W-1:0] op_wa, op_wb, op_b;
  logic                       fire;
  logic signed [ACC_W-1:0]    acc;
  logic                       unused_acc;

  neuron_eval #(
    .THRESHOLD (THRESHOLD)
  ) u_neuron_eval (
    .x1_i   (op_x1),
    .x2_i   (op_x2),
    .wa_i   (op_wa),
    .wb_i   (op_wb),
    .b_i    (op_b),
    .fire_o (fire),
    .acc_o  (acc)
  );

  assign unused_acc = ^acc;

  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && sched_io.out_ready);
  assign cfg_ok   = sched_io.cfg_we && (state_q == StIdle) && (sched_io.cfg_addr <= IDX_C_B);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    h_a_d     = h_a_q;
    h_b_d     = h_b_q;
    out_y_d   = out_y_q;
    weights_d = weights_q;
    op_x1     = 1'b0;
    op_x2     = 1'b0;
    op_wa     = '0;
    op_wb     = '0;
    op_b      = '0;
    cfg_err_d = sched_io.cfg_we && !cfg_ok;

    for (int unsigned i = 0; i < NUM_WEIGHTS; i++) begin
      if (cfg_ok && (sched_io.cfg_addr == 4'(i))) begin
        weights_d[i] = sched_io.cfg_wdata;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (sched_io.in_valid) begin
          x_d     = sched_io.in_x;
          state_d = StEvalA;
        end
      end
      StEvalA: begin
        op_x1   = x_q[0];
        op_x2   = x_q[1];
        op_wa   = weights_q[IDX_A_WA];
        op_wb   = weights_q[IDX_A_WB];
        op_b    = weights_q[IDX_A_B];
        h_a_d   = fire;
        state_d = StEvalB;
      end
      StEvalB: begin
        op_x1   = x_q[0];
        op_x2   = x_q[1];
        op_wa   = weights_q[IDX_B_WA];
        op_wb   = weights_q[IDX_B_WB];
        op_b    = weights_q[IDX_B_B];
        h_b_d   = fire;
        state_d = StEvalC;
      end
      StEvalC: begin
        op_x1   = h_a_q;
        op_x2   = h_b_q;
        op_wa   = weights_q[IDX_C_WA];
        op_wb   = weights_q[IDX_C_WB];
        op_b    = weights_q[IDX_C_B];
        out_y_d = fire;
        state_d = StDone;
      end
      StDone: begin
        // Result drains and, if a sample waits, it is taken in the same cycle.
        if (sched_io.out_ready) begin
          if (sched_io.in_valid) begin
            x_d     = sched_io.in_x;
            state_d = StEvalA;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      h_a_q     <= 1'b0;
      h_b_q     <= 1'b0;
      out_y_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      weights_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      h_a_q     <= h_a_d;
      h_b_q     <= h_b_d;
      out_y_q   <= out_y_d;
      cfg_err_q <= cfg_err_d;
      weights_q <= weights_d;
    end
  end

  assign sched_io.in_ready  = in_ready;
  assign sched_io.cfg_ready = (state_q == StIdle);
  assign sched_io.cfg_err   = cfg_err_q;
  assign sched_io.out_valid = (state_q == StDone);
  assign sched_io.out_y     = out_y_q;
  assign sched_io.busy      = (state_q != StIdle);

endmodule

// File: doc/mlp_node_scheduler.md
# mlp_node_scheduler

Time-multiplexed sequencer for the 2-2-1 threshold-neuron network: holds the nine signed 4-bit weights in a writable register file and steps one shared neuron evaluator through hidden nodes A and B and output node C. Input samples arrive and results leave on valid/ready handshakes. The block replaces three parallel neuron instances with one evaluator and adds runtime weight loading.

## Interface
- `WEIGHT_W`, 4: signed weight/bias width.
- `ACC_W`, 6: signed pre-activation width.
- `THRESHOLD`, 0: signed `ACC_W` firing threshold, strict greater-than.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_we` in 1: weight write strobe.
- `cfg_addr` in 4: weight index 0..8.
- `cfg_wdata` in `WEIGHT_W`: signed weight value.
- `cfg_ready` out 1: writes accepted this cycle.
- `cfg_err` out 1: one-cycle pulse when a write is dropped.
- `in_valid` in 1, `in_ready` out 1, `in_x` in 2: input sample {x1,x0}.
- `out_valid` out 1, `out_ready` in 1, `out_y` out 1: network output.
- `busy` out 1: state ≠ IDLE.

## Operation
- Weight map: 0 = A.wA, 1 = A.wB, 2 = A.b, 3 = B.wA, 4 = B.wB, 5 = B.b, 6 = C.wA, 7 = C.wB, 8 = C.b.
  - Node A and node B take inputs (x0, x1). Node C takes inputs (h_a, h_b).
- Neuron function: `acc = x1*wA + x2*wB - b`.
  - Inputs are 0/1, zero-extended. Weights are sign-extended to `ACC_W`.
  - Range -23..22 fits 6 bits; no saturation logic.
  - Fire = `acc > THRESHOLD`.
- Weight writes:
  - Accepted only when `cfg_ready` = (state == IDLE).
  - `cfg_we` with `cfg_addr` > 8, or `cfg_we` while not IDLE: write dropped, `cfg_err` = 1 for the next cycle.
- FSM states: IDLE, EVAL_A, EVAL_B, EVAL_C, DONE.
  - IDLE → EVAL_A on `in_valid & in_ready`; `in_x` is latched.
  - EVAL_A → EVAL_B: register h_a.
  - EVAL_B → EVAL_C: register h_b.
  - EVAL_C → DONE: register `out_y`, set `out_valid`.
  - DONE → IDLE on `out_ready` with no new input.
  - DONE → EVAL_A on `out_ready & in_valid`: back-to-back accept.
- `in_ready` = IDLE | (DONE & `out_ready`).
- `out_valid` and `out_y` are held stable in DONE until `out_ready`.
- A weight write and a sample accept in the same IDLE cycle are both taken; the accepted sample uses the new weight.

## Timing
- Reset values (while `rst_n` = 0 and immediately after release):
  - State IDLE; all weights 0; h_a, h_b, latched x = 0.
  - `out_valid` 0, `out_y` 0, `cfg_err` 0, `busy` 0.
  - `in_ready` and `cfg_ready` read 1; no transfer or write occurs while `rst_n` is low.
- Latency: sample accepted at edge k → `out_valid` = 1 after edge k+3.
- Throughput: one sample per 4 cycles with `out_ready` tied high.
- Reset asserted mid-evaluation aborts immediately. Partial h_a/h_b are discarded and weights clear. No `out_valid` is produced for the aborted sample.
- `out_ready` without `out_valid` is ignored. `in_valid` while `in_ready` = 0 must be held by the source (standard valid/ready).

## Structure
- `mlp_pkg`: state enum, `WEIGHT_W`, `ACC_W`, weight index constants (IDX_A_WA … IDX_C_B), `NUM_WEIGHTS` = 9.
- Sub-module `neuron_eval`: purely combinational. Inputs x1, x2, wA, wB, b; outputs fire and acc.
  - The scheduler muxes operands into it per state and registers its output.

## Test plan
- Reset: assert `rst_n` = 0 mid-EVAL_B → `out_valid` = 0, `busy` = 0. After release, sample x = 2'b11 with all-zero weights gives `out_y` = 0 (acc 0, not > 0).
- XOR load (A = 1,1,0; B = -1,-1,-2; C = 1,1,1), samples 00, 01, 10, 11 → `out_y` 0, 1, 1, 0. Each `out_valid` appears exactly 3 edges after its accept.
- Back-to-back with `out_ready` = 1 and `in_valid` = 1 continuously → one result every 4 cycles; `in_ready` high only in IDLE/DONE cycles.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE → `out_y` stable, `in_ready` = 0, then a single transfer.
- Config errors: write addr 9 in IDLE → `cfg_err` pulse, weights unchanged. Write addr 0 during EVAL_A → `cfg_err` pulse, result uses the old weight.
- Range: A = (7, 7, -8) with x = 11 → acc = 22, h_a = 1. A = (-8, -8, 7) → acc = -23, h_a = 0. No wrap.
